led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer (OFF / BLINK / CHASE / COUNT) stepped by a base-tick prescaler.
// Optional build macro LED_SEQ_CTRL_DIM_EN gates lit LEDs down to 25% duty.
//
// state  | meaning
// S_IDLE | no pattern running, ready for a command
// S_LOAD | one cycle: clear timing, set initial pattern
// S_RUN  | pattern advances every latched-period base ticks
module led_seq_ctrl #(
   parameter int unsigned TICK_DIV = 26_000_000,
   parameter int unsigned N_LED    = 4
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_mode,
   input  logic [7:0]       cmd_period,
   output logic             cmd_ready,
   output logic [N_LED-1:0] led,
   output logic             busy
);
   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [1:0]  M_BLINK   = 2'd1;
   localparam logic [1:0]  M_CHASE   = 2'd2;
   localparam logic [1:0]  M_COUNT   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [31:0]      presc_q, presc_d;
   logic [7:0]       step_q, step_d;
   logic [1:0]       mode_q, mode_d;
   logic [7:0]       period_q, period_d;
   logic [N_LED-1:0] pat_q, pat_d;
   logic [N_LED-1:0] led_q;
   logic             tick;
   logic             accept;

   assign tick      = (presc_q == TICK_LAST);
   assign cmd_ready = (state_q != S_LOAD);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q == S_RUN);

   function automatic logic [N_LED-1:0] initial_pat(input logic [1:0] mode);
      case (mode)
         M_BLINK: return '1;
         M_CHASE: return N_LED'(1);
         default: return '0;
      endcase
   endfunction

   function automatic logic [N_LED-1:0] advance(input logic [1:0] mode,
                                                input logic [N_LED-1:0] pat);
      case (mode)
         M_BLINK: return ~pat;
         M_CHASE: return {pat[N_LED-2:0], pat[N_LED-1]};
         M_COUNT: return pat + N_LED'(1);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      presc_d  = tick ? 32'd0 : presc_q + 32'd1;
      step_d   = step_q;
      mode_d   = mode_q;
      period_d = period_q;
      pat_d    = pat_q;

      // The command is captured on the accept edge so it is stable throughout LOAD.
      if (accept) begin
         mode_d   = cmd_mode;
         period_d = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_LOAD;
         end
         S_LOAD: begin
            presc_d = 32'd0;
            step_d  = 8'd0;
            pat_d   = initial_pat(mode_q);
            state_d = (mode_q != 2'd0) ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            if (accept) begin
               state_d = S_LOAD;
            end else if (tick) begin
               if (step_q + 8'd1 == period_q) begin
                  step_d = 8'd0;
                  pat_d  = advance(mode_q, pat_q);
               end else begin
                  step_d = step_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         presc_q  <= 32'd0;
         step_q   <= 8'd0;
         mode_q   <= 2'd0;
         period_q <= 8'd0;
         pat_q    <= '0;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         step_q   <= step_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         pat_q    <= pat_d;
         led_q    <= pat_q;
      end
   end

`ifdef LED_SEQ_CTRL_DIM_EN
   logic [1:0] dim_q;

   always_ff @(posedge sysclk) begin
      if (rst) dim_q <= 2'd0;
      else     dim_q <= dim_q + 2'd1;
   end

   assign led = (dim_q == 2'd0) ? led_q : '0;
`else
   assign led = led_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=4, N_LED=4) against a closed-form pattern model.
// Honours LED_SEQ_CTRL_DIM_EN when the bundle is built with it.
module tb_led_seq_ctrl;
   localparam int TD = 4;
   localparam int NL = 4;

   logic          sysclk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_mode = 2'd0;
   logic [7:0]    cmd_period = 8'd0;
   logic          cmd_ready;
   logic [NL-1:0] led;
   logic          busy;

   always #5 sysclk = ~sysclk;

   led_seq_ctrl #(.TICK_DIV(TD), .N_LED(NL)) dut (
      .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
      .cmd_period(cmd_period), .cmd_ready(cmd_ready), .led(led), .busy(busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Model: pattern is a pure function of mode and elapsed steps since RUN began.
   bit            m_load = 0;
   bit            m_run  = 0;
   logic [1:0]    m_mode = 0;
   int            m_per  = 0;
   int            m_t    = 0;
   logic [NL-1:0] m_pat  = '0;
   logic [NL-1:0] m_led  = '0;
   int            m_dim  = 0;

   function automatic logic [NL-1:0] pat_at(input logic [1:0] mode, input int k);
      case (mode)
         2'd1: return (k % 2 != 0) ? '0 : '1;
         2'd2: return NL'(1 << (k % NL));
         2'd3: return NL'(k % (1 << NL));
         default: return '0;
      endcase
   endfunction

   function automatic logic [NL-1:0] gate(input logic [NL-1:0] l);
`ifdef LED_SEQ_CTRL_DIM_EN
      if (m_dim != 0) return '0;
`endif
      return l;
   endfunction

   function automatic logic [NL+1:0] exp_vec();
      return {gate(m_led), m_run, !m_load};
   endfunction

   task automatic step();
      bit acc;
      acc = cmd_valid && !m_load;
      @(posedge sysclk);
      if (rst) begin
         m_load = 0; m_run = 0; m_mode = 0; m_per = 0; m_t = 0;
         m_pat = '0; m_led = '0; m_dim = 0;
      end else begin
         m_led = m_pat;
         m_dim = (m_dim + 1) % 4;
         if (acc) begin
            m_load = 1; m_run = 0; m_mode = cmd_mode;
            m_per = (cmd_period == 0) ? 1 : int'(cmd_period);
         end else if (m_load) begin
            m_load = 0; m_run = (m_mode != 0); m_t = 0;
            m_pat = pat_at(m_mode, 0);
         end else if (m_run) begin
            m_t++;
            m_pat = pat_at(m_mode, m_t / (m_per * TD));
         end
      end
      #1;
   endtask

   task automatic issue(input logic [1:0] mode, input logic [7:0] per);
      cmd_valid = 1'b1; cmd_mode = mode; cmd_period = per;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_period = 8'd1;
      step(); step();
      n_vec++;
      if ({led, busy, cmd_ready} !== {4'b0000, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state got led=%b busy=%b rdy=%b want 0000/0/1", led, busy, cmd_ready);
      end
      rst = 1'b0; cmd_valid = 1'b0;
      step();
      n_vec++;
      if ({led, busy, cmd_ready} !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset_release got %b want %b", {led, busy, cmd_ready}, exp_vec());
      end
   endtask

   task automatic test_blink();
      issue(2'd1, 8'd2);
      step(); step();
      n_vec++;
      if (led !== gate(4'b1111) || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL blink_first got led=%b busy=%b want %b/1", led, busy, gate(4'b1111));
      end
      for (int i = 1; i <= 4; i++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            n_vec++;
            if ({led, busy, cmd_ready} !== exp_vec()) begin
               n_bad++;
               $display("FAIL blink_model got %b want %b", {led, busy, cmd_ready}, exp_vec());
            end
         end
         n_vec++;
         if (led !== gate((i % 2 != 0) ? 4'b0000 : 4'b1111)) begin
            n_bad++;
            $display("FAIL blink_toggle%0d got led=%b", i, led);
         end
      end
   endtask

   task automatic test_chase();
      logic [NL-1:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      issue(2'd2, 8'd1);
      step(); step();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            for (int c = 0; c < 4; c++) begin
               step();
               n_vec++;
               if ({led, busy, cmd_ready} !== exp_vec()) begin
                  n_bad++;
                  $display("FAIL chase_model got %b want %b", {led, busy, cmd_ready}, exp_vec());
               end
            end
         end
         n_vec++;
         if (led !== gate(seq[i])) begin
            n_bad++;
            $display("FAIL chase_step%0d got led=%b want %b", i, led, gate(seq[i]));
         end
      end
   endtask

   task automatic test_count();
      issue(2'd3, 8'd0);
      step(); step();
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            for (int c = 0; c < 4; c++) begin
               step();
               n_vec++;
               if ({led, busy, cmd_ready} !== exp_vec()) begin
                  n_bad++;
                  $display("FAIL count_model got %b want %b", {led, busy, cmd_ready}, exp_vec());
               end
            end
         end
         n_vec++;
         if (led !== gate(4'(i % 16))) begin
            n_bad++;
            $display("FAIL count_val%0d got led=%b want %b", i, led, gate(4'(i % 16)));
         end
      end
   endtask

   task automatic test_preempt_tick();
      logic [NL-1:0] p;
      bit found;
      found = 0;
      issue(2'd2, 8'd1);
      for (int c = 0; c < 60 && !found; c++) begin
         step();
         if (m_run && m_t > 4 && (m_t % TD) == TD - 1) found = 1;
      end
      n_vec++;
      if (!found) begin
         n_bad++;
         $display("FAIL preempt_wait got no tick cycle within budget want one");
         return;
      end
      p = m_pat;
      issue(2'd0, 8'd5);
      n_vec++;
      if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL preempt_load got rdy=%b busy=%b want 0/0", cmd_ready, busy);
      end
      step();
      n_vec++;
      if ({led, busy, cmd_ready} !== {gate(p), 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL preempt_nostep got led=%b busy=%b rdy=%b want %b/0/1", led, busy, cmd_ready, gate(p));
      end
      step();
      n_vec++;
      if ({led, busy, cmd_ready} !== 6'b0000_0_1) begin
         n_bad++;
         $display("FAIL preempt_off got led=%b busy=%b rdy=%b want 0000/0/1", led, busy, cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 0;
      issue(2'd3, 8'd1);
      for (int c = 0; c < 100 && !found; c++) begin
         step();
         if (m_run && m_led == 4'b0101) found = 1;
      end
      n_vec++;
      if (!found || led !== gate(4'b0101)) begin
         n_bad++;
         $display("FAIL rstmid_reach got led=%b want %b", led, gate(4'b0101));
      end
      rst = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_period = 8'd1;
      step();
      n_vec++;
      if (led !== 4'b0000 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_abort got led=%b busy=%b want 0000/0", led, busy);
      end
      rst = 1'b0; cmd_valid = 1'b0;
      step(); step();
      n_vec++;
      if ({led, busy, cmd_ready} !== 6'b0000_0_1) begin
         n_bad++;
         $display("FAIL rstmid_noaccept got led=%b busy=%b rdy=%b want 0000/0/1", led, busy, cmd_ready);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         cmd_valid  = ($urandom_range(0, 24) == 0);
         cmd_mode   = 2'($urandom_range(0, 3));
         cmd_period = 8'($urandom_range(0, 3));
         step();
         n_vec++;
         if ({led, busy, cmd_ready} !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_c%0d got %b want %b", c, {led, busy, cmd_ready}, exp_vec());
         end
      end
      rst = 1'b0; cmd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_blink();
      test_chase();
      test_count();
      test_preempt_tick();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end
endmodule
